// File: rtl/hdmi_tg_pkg.sv
// Shared types and helpers for the HDMI timing generator: phase encoding,
// controller states and the zero-length clamp applied to timing fields.
package hdmi_tg_pkg;

    localparam int CW_DEFAULT = 11;

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FP     = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BP     = 2'd3
    } phase_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // A programmed length of zero behaves as a one-clock (or one-line) phase.
    function automatic logic [31:0] clamp1(input logic [31:0] len);
        logic [31:0] r;
        if (len == 32'd0) begin
            r = 32'd1;
        end else begin
            r = len;
        end
        return r;
    endfunction

endpackage

// File: rtl/hdmi_tg_axis.sv
// One raster axis: walks ACTIVE -> FP -> SYNC -> BP, one step per 'adv'.
// 'last' marks the final step of BP, i.e. the wrap back to ACTIVE.
module hdmi_tg_axis
    import hdmi_tg_pkg::*;
#(
    parameter int CW = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hold,
    input  logic          adv,
    input  logic [CW-1:0] len_active,
    input  logic [CW-1:0] len_fp,
    input  logic [CW-1:0] len_sync,
    input  logic [CW-1:0] len_bp,
    output phase_t        phase,
    output logic [CW-1:0] cnt,
    output logic          last
);

    logic [CW-1:0] len_cur;
    logic [CW-1:0] len_eff;
    phase_t        phase_nxt;
    logic          phase_done;

    // Select the length of the current phase and its successor.
    always_comb begin
        len_cur   = len_active;
        phase_nxt = PH_FP;
        case (phase)
            PH_ACTIVE: begin len_cur = len_active; phase_nxt = PH_FP;     end
            PH_FP:     begin len_cur = len_fp;     phase_nxt = PH_SYNC;   end
            PH_SYNC:   begin len_cur = len_sync;   phase_nxt = PH_BP;     end
            PH_BP:     begin len_cur = len_bp;     phase_nxt = PH_ACTIVE; end
            default:   begin len_cur = len_active; phase_nxt = PH_ACTIVE; end
        endcase
    end

    assign len_eff    = CW'(clamp1(32'(len_cur)));
    assign phase_done = (cnt == (len_eff - CW'(1)));
    assign last       = (phase == PH_BP) && phase_done;

    // Phase and in-phase counter; held at the start of ACTIVE while idle.
    always_ff @(posedge clk) begin
        if (rst || hold) begin
            phase <= PH_ACTIVE;
            cnt   <= {CW{1'b0}};
        end else if (adv) begin
            if (phase_done) begin
                phase <= phase_nxt;
                cnt   <= {CW{1'b0}};
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/hdmi_timing_gen.sv
// HDMI video timing controller, 2 pixels per clock. Optional colour-bar
// source enabled by defining HDMI_TG_TEST_PATTERN_EN (adds cfg_pattern).
module hdmi_timing_gen
    import hdmi_tg_pkg::*;
#(
    parameter int DW  = 12,
    parameter int LAT = 2,
    parameter int CW  = CW_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic [CW-1:0]   cfg_h_active,
    input  logic [CW-1:0]   cfg_h_fp,
    input  logic [CW-1:0]   cfg_h_sync,
    input  logic [CW-1:0]   cfg_h_bp,
    input  logic [CW-1:0]   cfg_v_active,
    input  logic [CW-1:0]   cfg_v_fp,
    input  logic [CW-1:0]   cfg_v_sync,
    input  logic [CW-1:0]   cfg_v_bp,
    input  logic            cfg_hs_pol,
    input  logic            cfg_vs_pol,
`ifdef HDMI_TG_TEST_PATTERN_EN
    input  logic            cfg_pattern,
`endif
    output logic            px_req,
    output logic [CW-1:0]   px_x,
    output logic [CW-1:0]   px_y,
    output logic            px_sof,
    input  logic [2*DW-1:0] px_data,
    output logic [2*DW-1:0] out_data,
    output logic            out_hsync,
    output logic            out_vsync,
    output logic            out_de,
    output logic            frame_start
);

    state_t        state;
    logic [CW-1:0] sh_h_active, sh_h_fp, sh_h_sync, sh_h_bp;
    logic [CW-1:0] sh_v_active, sh_v_fp, sh_v_sync, sh_v_bp;
    logic          sh_hs_pol, sh_vs_pol;
    phase_t        h_ph, v_ph;
    logic [CW-1:0] h_cnt, v_cnt;
    logic          h_last, v_last;
    logic          run, frame_end, load;
    logic          raw_de, raw_hs, raw_vs;
    logic          d_de, d_hs, d_vs;
    logic          hs_pol, vs_pol;
    logic [2*DW-1:0] data_sel;

    assign run       = (state == ST_RUN);
    assign frame_end = run && h_last && v_last;
    assign load      = (state == ST_IDLE) || frame_end;

    hdmi_tg_axis #(.CW(CW)) u_h (
        .clk(clk), .rst(rst), .hold(!run), .adv(1'b1),
        .len_active(sh_h_active), .len_fp(sh_h_fp),
        .len_sync(sh_h_sync), .len_bp(sh_h_bp),
        .phase(h_ph), .cnt(h_cnt), .last(h_last)
    );

    hdmi_tg_axis #(.CW(CW)) u_v (
        .clk(clk), .rst(rst), .hold(!run), .adv(h_last),
        .len_active(sh_v_active), .len_fp(sh_v_fp),
        .len_sync(sh_v_sync), .len_bp(sh_v_bp),
        .phase(v_ph), .cnt(v_cnt), .last(v_last)
    );

    // Controller: leaves RUN only on a frame boundary so frames are never cut short.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (enable) state <= ST_RUN;
                ST_RUN:  if (frame_end && !enable) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Shadow timing: follows cfg while idle, otherwise latched on the last frame clock.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            sh_h_active <= cfg_h_active;
            sh_h_fp     <= cfg_h_fp;
            sh_h_sync   <= cfg_h_sync;
            sh_h_bp     <= cfg_h_bp;
            sh_v_active <= cfg_v_active;
            sh_v_fp     <= cfg_v_fp;
            sh_v_sync   <= cfg_v_sync;
            sh_v_bp     <= cfg_v_bp;
            sh_hs_pol   <= cfg_hs_pol;
            sh_vs_pol   <= cfg_vs_pol;
        end
    end

    assign raw_de      = run && (h_ph == PH_ACTIVE) && (v_ph == PH_ACTIVE);
    assign raw_hs      = run && (h_ph == PH_SYNC);
    assign raw_vs      = run && (v_ph == PH_SYNC);
    assign px_req      = raw_de;
    assign px_x        = h_cnt;
    assign px_y        = v_cnt;
    assign px_sof      = raw_de && (h_cnt == {CW{1'b0}}) && (v_cnt == {CW{1'b0}});
    assign frame_start = px_sof;

`ifdef HDMI_TG_TEST_PATTERN_EN
    localparam int PW = 6;
    logic       sh_pattern;
    logic [2:0] d_bar;
    logic [DW-1:0] bar_px;

    // Pattern select is shadowed with the timing so it changes between frames only.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            sh_pattern <= cfg_pattern;
        end
    end
`else
    localparam int PW = 3;
`endif

    logic [PW-1:0] pipe_in, pipe_out;

`ifdef HDMI_TG_TEST_PATTERN_EN
    assign pipe_in  = {h_cnt[6:4], raw_de, raw_hs, raw_vs};
    assign d_bar    = pipe_out[5:3];
    assign bar_px   = {{(DW/3){d_bar[2]}}, {(DW/3){d_bar[1]}}, {(DW/3){d_bar[0]}}};
    assign data_sel = sh_pattern ? {bar_px, bar_px} : px_data;
`else
    assign pipe_in  = {raw_de, raw_hs, raw_vs};
    assign data_sel = px_data;
`endif

    generate
        if (LAT == 0) begin : g_nodly
            assign pipe_out = pipe_in;
        end else begin : g_dly
            logic [PW-1:0] sr [LAT];
            // Delay line matching the pixel source fetch latency.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < LAT; i++) sr[i] <= {PW{1'b0}};
                end else begin
                    sr[0] <= pipe_in;
                    for (int i = 1; i < LAT; i++) sr[i] <= sr[i-1];
                end
            end
            assign pipe_out = sr[LAT-1];
        end
    endgenerate

    assign d_de   = pipe_out[2];
    assign d_hs   = pipe_out[1];
    assign d_vs   = pipe_out[0];
    // Idle syncs track the live polarity; a running frame uses its shadow copy.
    assign hs_pol = run ? sh_hs_pol : cfg_hs_pol;
    assign vs_pol = run ? sh_vs_pol : cfg_vs_pol;

    // PHY-facing output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_de    <= 1'b0;
            out_data  <= {(2*DW){1'b0}};
            out_hsync <= ~cfg_hs_pol;
            out_vsync <= ~cfg_vs_pol;
        end else begin
            out_de    <= d_de;
            out_data  <= d_de ? data_sel : {(2*DW){1'b0}};
            out_hsync <= d_hs ? hs_pol : ~hs_pol;
            out_vsync <= d_vs ? vs_pol : ~vs_pol;
        end
    end

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Directed bench for hdmi_timing_gen: small raster, pixel source with fetch
// latency, and a scoreboard pairing each px_req with its out_de/out_data beat.
module tb_hdmi_timing_gen;

    localparam int DW  = 12;
    localparam int LAT = 2;
    localparam int CW  = 11;

    logic            clk = 1'b0;
    logic            rst, enable;
    logic [CW-1:0]   cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp;
    logic [CW-1:0]   cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp;
    logic            cfg_hs_pol, cfg_vs_pol;
    logic            px_req, px_sof, out_hsync, out_vsync, out_de, frame_start;
    logic [CW-1:0]   px_x, px_y;
    logic [2*DW-1:0] px_data, d1, out_data;

    hdmi_timing_gen #(.DW(DW), .LAT(LAT), .CW(CW)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .cfg_h_active(cfg_h_active), .cfg_h_fp(cfg_h_fp),
        .cfg_h_sync(cfg_h_sync), .cfg_h_bp(cfg_h_bp),
        .cfg_v_active(cfg_v_active), .cfg_v_fp(cfg_v_fp),
        .cfg_v_sync(cfg_v_sync), .cfg_v_bp(cfg_v_bp),
        .cfg_hs_pol(cfg_hs_pol), .cfg_vs_pol(cfg_vs_pol),
        .px_req(px_req), .px_x(px_x), .px_y(px_y), .px_sof(px_sof),
        .px_data(px_data), .out_data(out_data),
        .out_hsync(out_hsync), .out_vsync(out_vsync), .out_de(out_de),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Pixel source: returns {y, x} of a request two clocks after it.
    always @(posedge clk) begin
        d1      <= 24'({px_y, px_x});
        px_data <= d1;
    end

    typedef struct {
        int          due;
        logic [23:0] data;
    } sb_t;
    sb_t sb[$];

    int   checks = 0, errors = 0, cyc = 0;
    int   req_cnt, fs_cnt, hs_act_cnt, vs_act_cnt, de_cnt, hs_first, fs_first, win_start;
    int   m_hact, ex, ey;
    logic act_hs, act_vs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        req_cnt = 0; fs_cnt = 0; hs_act_cnt = 0; vs_act_cnt = 0; de_cnt = 0;
        hs_first = -1; fs_first = -1; win_start = cyc + 1;
    endtask

    task automatic observe();
        sb_t e;
        if (px_req) begin
            req_cnt++;
            if (px_sof) begin ex = 0; ey = 0; end
            chk("px_x", 32'(px_x), ex);
            chk("px_y", 32'(px_y), ey);
            sb.push_back('{cyc + LAT + 1, 24'({CW'(ey), CW'(ex)})});
            ex++;
            if (ex == m_hact) begin ex = 0; ey++; end
        end
        if (frame_start) begin
            fs_cnt++;
            if (fs_first < 0) fs_first = cyc - win_start;
        end
        if (out_hsync === act_hs) begin
            hs_act_cnt++;
            if (hs_first < 0) hs_first = cyc - win_start;
        end
        if (out_vsync === act_vs) vs_act_cnt++;
        if (out_de) begin
            de_cnt++;
            chk("de_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("de_time", cyc, e.due);
                chk("out_data", 32'(out_data), 32'(e.data));
            end
        end else begin
            chk("blank_data", 32'(out_data), 32'd0);
            if (sb.size() > 0) chk("de_late", 32'(cyc < sb[0].due), 32'd1);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            observe();
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0;
        cfg_h_active = 11'd4; cfg_h_fp = 11'd1; cfg_h_sync = 11'd2; cfg_h_bp = 11'd1;
        cfg_v_active = 11'd3; cfg_v_fp = 11'd1; cfg_v_sync = 11'd1; cfg_v_bp = 11'd1;
        cfg_hs_pol = 1'b1; cfg_vs_pol = 1'b1;
        act_hs = 1'b1; act_vs = 1'b1; m_hact = 4; ex = 0; ey = 0;
        clr();
        run(2);
        chk("rst_de", 32'(out_de), 32'd0);
        chk("rst_req", 32'(px_req), 32'd0);
        chk("rst_hs", 32'(out_hsync), 32'd0);
        chk("rst_vs", 32'(out_vsync), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_fs", 32'(frame_start), 32'd0);

        rst = 1'b0;
        clr(); run(3);
        chk("idle_req", req_cnt, 32'd0);

        // First frame after enable
        enable = 1'b1;
        clr(); run(1);
        chk("first_req", 32'(px_req), 32'd1);
        chk("first_fs", 32'(frame_start), 32'd1);
        chk("first_sof", 32'(px_sof), 32'd1);
        run(47);
        chk("f1_req", req_cnt, 32'd12);
        chk("f1_fs", fs_cnt, 32'd1);
        chk("f1_hs_first", hs_first, 32'd8);
        chk("f1_de", de_cnt, 32'd12);

        // Steady-state frame
        clr(); run(48);
        chk("f2_req", req_cnt, 32'd12);
        chk("f2_fs", fs_cnt, 32'd1);
        chk("f2_fs_first", fs_first, 32'd0);
        chk("f2_hs_act", hs_act_cnt, 32'd12);
        chk("f2_vs_act", vs_act_cnt, 32'd8);
        chk("f2_de", de_cnt, 32'd12);

        // Mid-frame cfg change applies from the next frame only
        clr(); run(10);
        cfg_h_active = 11'd6;
        run(38);
        chk("f3_req", req_cnt, 32'd12);
        chk("f3_fs", fs_cnt, 32'd1);
        m_hact = 6;
        clr(); run(60);
        chk("f4_req", req_cnt, 32'd18);
        chk("f4_fs", fs_cnt, 32'd1);
        chk("f4_fs_first", fs_first, 32'd0);
        clr(); run(1);
        chk("f5_fs", 32'(frame_start), 32'd1);
        cfg_h_active = 11'd4;
        run(59);
        chk("f5_req", req_cnt, 32'd18);

        // Enable drop mid-frame: frame completes, then idle
        m_hact = 4;
        clr(); run(20);
        enable = 1'b0;
        run(28);
        chk("f6_req", req_cnt, 32'd12);
        chk("f6_fs", fs_cnt, 32'd1);
        clr(); run(12);
        chk("post_req", req_cnt, 32'd0);
        chk("post_fs", fs_cnt, 32'd0);
        chk("post_de", 32'(out_de), 32'd0);

        // Active-low syncs and a zero front porch
        cfg_hs_pol = 1'b0; cfg_vs_pol = 1'b0; cfg_h_fp = 11'd0;
        act_hs = 1'b0; act_vs = 1'b0;
        run(2);
        chk("pol_idle_hs", 32'(out_hsync), 32'd1);
        chk("pol_idle_vs", 32'(out_vsync), 32'd1);
        enable = 1'b1;
        clr(); run(48);
        chk("p1_req", req_cnt, 32'd12);
        chk("p1_fs", fs_cnt, 32'd1);
        chk("p1_hs_first", hs_first, 32'd8);
        clr(); run(48);
        enable = 1'b0;
        chk("p2_req", req_cnt, 32'd12);
        chk("p2_hs_act", hs_act_cnt, 32'd12);
        chk("p2_vs_act", vs_act_cnt, 32'd8);
        clr(); run(10);
        chk("p3_req", req_cnt, 32'd0);

        // Reset in the middle of a frame
        cfg_hs_pol = 1'b1; cfg_vs_pol = 1'b1; cfg_h_fp = 11'd1;
        act_hs = 1'b1; act_vs = 1'b1;
        run(2);
        enable = 1'b1;
        clr(); run(30);
        rst = 1'b1;
        sb.delete();
        run(1);
        chk("rr_de", 32'(out_de), 32'd0);
        chk("rr_req", 32'(px_req), 32'd0);
        chk("rr_hs", 32'(out_hsync), 32'd0);
        chk("rr_vs", 32'(out_vsync), 32'd0);
        chk("rr_data", 32'(out_data), 32'd0);
        rst = 1'b0;
        clr(); run(1);
        chk("rr_fs", 32'(frame_start), 32'd1);
        chk("rr_x", 32'(px_x), 32'd0);
        chk("rr_y", 32'(px_y), 32'd0);
        run(47);
        enable = 1'b0;
        chk("rr_req_cnt", req_cnt, 32'd12);
        run(6);
        chk("sb_drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
